// File: rtl/trap_ctrl.sv
// trap_ctrl: takes exceptions, interrupts and mret, sequences the CSR trap-channel
// writes and redirects fetch to mtvec or mepc.
module trap_ctrl #(
   parameter bit MTVAL_EN  = 1'b1,
   parameter bit VECTOR_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ecall_i,
   input  logic        ebreak_i,
   input  logic        illegal_i,
   input  logic        mret_i,
   input  logic [31:0] inst_i,
   input  logic [31:0] inst_pc_i,
   input  logic [31:0] next_pc_i,
   input  logic        ex_trap_valid_i,
   input  logic        tcmp_trap_valid_i,
   input  logic        soft_trap_valid_i,
   input  logic        mstatus_MIE3,
   input  logic [31:0] mepc,
   output logic        trap_csr_we_o,
   output logic [11:0] trap_csr_addr_o,
   output logic [31:0] trap_csr_wdata_o,
   input  logic [31:0] trap_csr_rdata_i,
   output logic        trap_busy_o,
   output logic        trap_jump_o,
   output logic [31:0] trap_jump_pc_o
);
   typedef enum logic [2:0] {
      IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, JUMP, M_MSTATUS, M_JUMP
   } state_t;
   state_t      state_q, state_d;
   logic [31:0] cause_q, cause_d, epc_q, epc_d, tval_q, tval_d;
   logic        busy_q, busy_d;
   logic        irq_en;
   logic [31:0] base;
   always_comb begin
      state_d          = state_q;
      cause_d          = cause_q;
      epc_d            = epc_q;
      tval_d           = tval_q;
      irq_en           = mstatus_MIE3 & (ex_trap_valid_i | tcmp_trap_valid_i | soft_trap_valid_i);
      base             = {trap_csr_rdata_i[31:2], 2'b00};
      trap_csr_we_o    = 1'b0;
      trap_csr_addr_o  = '0;
      trap_csr_wdata_o = '0;
      trap_jump_o      = 1'b0;
      trap_jump_pc_o   = '0;
      case (state_q)
         IDLE: begin
            if (illegal_i | ebreak_i | ecall_i) begin
               state_d = W_MEPC;
               epc_d   = inst_pc_i;
               cause_d = illegal_i ? 32'd2 : ebreak_i ? 32'd3 : 32'd11;
               tval_d  = illegal_i ? inst_i : ebreak_i ? inst_pc_i : '0;
            end else if (mret_i) begin
               state_d = M_MSTATUS;
            end else if (irq_en) begin
               state_d = W_MEPC;
               epc_d   = next_pc_i;
               tval_d  = '0;
               cause_d = ex_trap_valid_i ? 32'h8000_000B : soft_trap_valid_i ? 32'h8000_0003 : 32'h8000_0007;
            end
         end
         W_MEPC: begin
            trap_csr_we_o    = 1'b1;
            trap_csr_addr_o  = 12'h341;
            trap_csr_wdata_o = epc_q;
            state_d          = W_MCAUSE;
         end
         W_MCAUSE: begin
            trap_csr_we_o    = 1'b1;
            trap_csr_addr_o  = 12'h342;
            trap_csr_wdata_o = cause_q;
            state_d          = MTVAL_EN ? W_MTVAL : W_MSTATUS;
         end
         W_MTVAL: begin
            trap_csr_we_o    = 1'b1;
            trap_csr_addr_o  = 12'h343;
            trap_csr_wdata_o = tval_q;
            state_d          = W_MSTATUS;
         end
         W_MSTATUS: begin
            trap_csr_we_o    = 1'b1;
            trap_csr_addr_o  = 12'h300;
            trap_csr_wdata_o = {trap_csr_rdata_i[31:8], trap_csr_rdata_i[3], trap_csr_rdata_i[6:4],
                                1'b0, trap_csr_rdata_i[2:0]};
            state_d          = JUMP;
         end
         JUMP: begin
            trap_csr_addr_o = 12'h305;
            trap_jump_o     = 1'b1;
            // vectored offset is 4 * cause code; exceptions always land on the base
            trap_jump_pc_o  = (VECTOR_EN && trap_csr_rdata_i[0] && cause_q[31]) ?
                              base + {cause_q[28:0], 2'b00} : base;
            state_d         = IDLE;
         end
         M_MSTATUS: begin
            trap_csr_we_o    = 1'b1;
            trap_csr_addr_o  = 12'h300;
            trap_csr_wdata_o = {trap_csr_rdata_i[31:8], 1'b1, trap_csr_rdata_i[6:4],
                                trap_csr_rdata_i[7], trap_csr_rdata_i[2:0]};
            state_d          = M_JUMP;
         end
         M_JUMP: begin
            trap_jump_o    = 1'b1;
            trap_jump_pc_o = mepc;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = state_d != IDLE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cause_q <= '0;
         epc_q   <= '0;
         tval_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         epc_q   <= epc_d;
         tval_q  <= tval_d;
         busy_q  <= busy_d;
      end
   end
   assign trap_busy_o = busy_q;
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: drives trap_ctrl against a small CSR-file model and checks write
// sequences, redirect targets and timing.
module tb_trap_ctrl;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        ecall_i, ebreak_i, illegal_i, mret_i;
   logic [31:0] inst_i, inst_pc_i, next_pc_i;
   logic        ex_i, tcmp_i, soft_i;
   logic        csr_we, trap_busy_o, trap_jump_o;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata, csr_rdata, trap_jump_pc_o;
   logic [31:0] m_status, m_tvec, m_epc, m_cause, m_tval;
   typedef struct {logic [11:0] a; logic [31:0] d;} wr_t;
   typedef struct {
      logic [3:0]  req;
      logic [2:0]  irq;
      logic [31:0] pc, npc, inst, tvec, stat, epc0;
      logic [31:0] x_jpc, x_cause, x_epc, x_tval, x_stat;
      int          x_lat;
   } vec_t;
   wr_t         exp_w[$], got_w[$];
   int          checks = 0, errors = 0;
   int          jump_k, busy_n, idle_bad, exp_lat;
   logic [31:0] jump_pc, exp_tgt;
   vec_t        vt[10];
   always #5 clk = ~clk;
   always_comb begin
      case (csr_addr)
         12'h300: csr_rdata = m_status;
         12'h305: csr_rdata = m_tvec;
         12'h341: csr_rdata = m_epc;
         12'h342: csr_rdata = m_cause;
         12'h343: csr_rdata = m_tval;
         default: csr_rdata = '0;
      endcase
   end
   trap_ctrl dut (
      .clk(clk), .rst_n(rst_n), .ecall_i(ecall_i), .ebreak_i(ebreak_i), .illegal_i(illegal_i),
      .mret_i(mret_i), .inst_i(inst_i), .inst_pc_i(inst_pc_i), .next_pc_i(next_pc_i),
      .ex_trap_valid_i(ex_i), .tcmp_trap_valid_i(tcmp_i), .soft_trap_valid_i(soft_i),
      .mstatus_MIE3(m_status[3]), .mepc(m_epc), .trap_csr_we_o(csr_we), .trap_csr_addr_o(csr_addr),
      .trap_csr_wdata_o(csr_wdata), .trap_csr_rdata_i(csr_rdata), .trap_busy_o(trap_busy_o),
      .trap_jump_o(trap_jump_o), .trap_jump_pc_o(trap_jump_pc_o)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
      case (a)
         12'h300: m_status = d;
         12'h305: m_tvec   = d;
         12'h341: m_epc    = d;
         12'h342: m_cause  = d;
         12'h343: m_tval   = d;
         default: ;
      endcase
   endtask
   // Reference: req = {illegal, ebreak, ecall, mret}, irq = {ext, soft, timer}
   task automatic model(input logic [3:0] req, input logic [2:0] irq,
                        input logic [31:0] pc, input logic [31:0] npc, input logic [31:0] inst);
      logic [31:0] cause, epc, tval, ms;
      logic        take;
      exp_w.delete();
      take = 1'b1;
      tval = 0;
      epc  = pc;
      cause = 0;
      if (req[3]) begin cause = 2; tval = inst; end
      else if (req[2]) begin cause = 3; tval = pc; end
      else if (req[1]) cause = 11;
      else if (req[0]) take = 1'b0;
      else if (m_status[3] && irq[2]) begin cause = 32'h8000_000B; epc = npc; end
      else if (m_status[3] && irq[1]) begin cause = 32'h8000_0003; epc = npc; end
      else if (m_status[3] && irq[0]) begin cause = 32'h8000_0007; epc = npc; end
      else take = 1'b0;
      ms = m_status;
      if (take) begin
         ms[7] = ms[3];
         ms[3] = 1'b0;
         exp_w.push_back('{12'h341, epc});
         exp_w.push_back('{12'h342, cause});
         exp_w.push_back('{12'h343, tval});
         exp_w.push_back('{12'h300, ms});
         exp_lat = 5;
         exp_tgt = (m_tvec & ~32'h3) + ((cause[31] && m_tvec[0]) ? (cause & 32'h7FFF_FFFF) * 4 : 0);
      end else if (req[0]) begin
         ms[3] = ms[7];
         ms[7] = 1'b1;
         exp_w.push_back('{12'h300, ms});
         exp_lat = 2;
         exp_tgt = m_epc;
      end else begin
         exp_lat = -1;
         exp_tgt = 0;
      end
   endtask
   task automatic run(input logic [3:0] req, input logic [2:0] irq,
                      input logic [31:0] pc, input logic [31:0] npc, input logic [31:0] inst);
      logic        w;
      logic [11:0] a;
      logic [31:0] d;
      got_w.delete();
      jump_k = -1; jump_pc = 0; busy_n = 0; idle_bad = 0;
      @(negedge clk);
      {illegal_i, ebreak_i, ecall_i, mret_i} = req;
      {ex_i, soft_i, tcmp_i} = irq;
      inst_pc_i = pc; next_pc_i = npc; inst_i = inst;
      @(posedge clk);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) begin
            {illegal_i, ebreak_i, ecall_i, mret_i} = '0;
            if (req[0]) {ex_i, soft_i, tcmp_i} = '0;
         end
         if (trap_busy_o) busy_n++;
         if (trap_jump_o) begin
            jump_k  = (jump_k < 0) ? k : 99;
            jump_pc = trap_jump_pc_o;
         end
         if (!trap_busy_o && (csr_we || trap_jump_o || csr_addr != 0 || csr_wdata != 0 || trap_jump_pc_o != 0))
            idle_bad++;
         w = csr_we; a = csr_addr; d = csr_wdata;
         if (w) got_w.push_back('{a, d});
         @(posedge clk);
         #1 if (w) csr_write(a, d);
      end
      {ex_i, soft_i, tcmp_i} = '0;
   endtask
   task automatic cmp_list(input string tag);
      chk({tag, "_nwr"}, got_w.size(), exp_w.size());
      for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
         chk({tag, "_addr"}, {20'b0, got_w[i].a}, {20'b0, exp_w[i].a});
         chk({tag, "_data"}, got_w[i].d, exp_w[i].d);
      end
      chk({tag, "_jcyc"}, jump_k, exp_lat);
      chk({tag, "_jpc"}, jump_pc, exp_tgt);
      chk({tag, "_busy"}, busy_n, exp_lat < 0 ? 0 : exp_lat);
      chk({tag, "_idle"}, idle_bad, 0);
   endtask
   initial begin
      {ecall_i, ebreak_i, illegal_i, mret_i, ex_i, tcmp_i, soft_i} = '0;
      inst_i = 0; inst_pc_i = 0; next_pc_i = 0;
      m_status = 0; m_tvec = 0; m_epc = 0; m_cause = 0; m_tval = 0;
      #12;
      chk("reset_ctl", {29'b0, csr_we, trap_busy_o, trap_jump_o}, 0);
      chk("reset_addr", {20'b0, csr_addr}, 0);
      chk("reset_wdata", csr_wdata, 0);
      chk("reset_jpc", trap_jump_pc_o, 0);
      @(negedge clk); rst_n = 1'b1;
      //       req     irq     pc           npc          inst         tvec         stat         epc0         jpc          cause        epc          tval         stat         lat
      vt[0] = '{4'b0010, 3'b000, 32'h100,     32'h104,     32'h73,      32'h200,     32'h8,       32'h0,       32'h200,     32'd11,      32'h100,     32'h0,       32'h80,      5};
      vt[1] = '{4'b0000, 3'b001, 32'h80,      32'h84,      32'h0,       32'h401,     32'h8,       32'h0,       32'h41C,     32'h80000007,32'h84,      32'h0,       32'h80,      5};
      vt[2] = '{4'b1000, 3'b010, 32'h40,      32'h44,      32'hFFFFFFFF,32'h101,     32'h8,       32'h0,       32'h100,     32'd2,       32'h40,      32'hFFFFFFFF,32'h80,      5};
      vt[3] = '{4'b0001, 3'b000, 32'h60,      32'h64,      32'h30200073,32'h200,     32'h80,      32'h3C,      32'h3C,      32'h0,       32'h3C,      32'h0,       32'h88,      2};
      vt[4] = '{4'b0100, 3'b000, 32'h1234,    32'h1238,    32'h00100073,32'h8001,    32'h1888,    32'h0,       32'h8000,    32'd3,       32'h1234,    32'h1234,    32'h1880,    5};
      vt[5] = '{4'b0000, 3'b011, 32'h1FFC,    32'h2000,    32'h0,       32'h301,     32'h8,       32'h0,       32'h30C,     32'h80000003,32'h2000,    32'h0,       32'h80,      5};
      vt[6] = '{4'b0001, 3'b111, 32'h0,       32'h4,       32'h0,       32'h200,     32'h8,       32'h500,     32'h500,     32'h0,       32'h500,     32'h0,       32'h80,      2};
      vt[7] = '{4'b0000, 3'b100, 32'h40,      32'h44,      32'h0,       32'h400,     32'h8,       32'h0,       32'h400,     32'h8000000B,32'h44,      32'h0,       32'h80,      5};
      vt[8] = '{4'b0110, 3'b000, 32'h10,      32'h14,      32'h0,       32'h202,     32'h0,       32'h0,       32'h200,     32'd3,       32'h10,      32'h10,      32'h0,       5};
      vt[9] = '{4'b0010, 3'b111, 32'h700,     32'h704,     32'h0,       32'h901,     32'h8,       32'h0,       32'h900,     32'd11,      32'h700,     32'h0,       32'h80,      5};
      foreach (vt[i]) begin
         m_status = vt[i].stat; m_tvec = vt[i].tvec; m_epc = vt[i].epc0; m_cause = 0; m_tval = 0;
         run(vt[i].req, vt[i].irq, vt[i].pc, vt[i].npc, vt[i].inst);
         chk($sformatf("v%0d_jcyc", i), jump_k, vt[i].x_lat);
         chk($sformatf("v%0d_jpc", i), jump_pc, vt[i].x_jpc);
         chk($sformatf("v%0d_mepc", i), m_epc, vt[i].x_epc);
         chk($sformatf("v%0d_mcause", i), m_cause, vt[i].x_cause);
         chk($sformatf("v%0d_mtval", i), m_tval, vt[i].x_tval);
         chk($sformatf("v%0d_mstatus", i), m_status, vt[i].x_stat);
         chk($sformatf("v%0d_busy", i), busy_n, vt[i].x_lat);
         chk($sformatf("v%0d_idle", i), idle_bad, 0);
      end
      m_status = 0; m_tvec = 32'h200; m_cause = 0; m_epc = 0;
      run(4'b0000, 3'b111, 32'h80, 32'h84, 32'h0);
      chk("mie0_nwr", got_w.size(), 0);
      chk("mie0_busy", busy_n, 0);
      chk("mie0_jcyc", jump_k, -1);
      m_status = 32'h8;
      run(4'b0000, 3'b111, 32'h80, 32'h88, 32'h0);
      chk("mie1_mcause", m_cause, 32'h8000_000B);
      chk("mie1_mepc", m_epc, 32'h88);
      chk("mie1_jpc", jump_pc, 32'h200);
      chk("mie1_mstatus", m_status, 32'h80);
      m_status = 32'h8; m_tvec = 32'h200; m_epc = 0; m_cause = 0;
      @(negedge clk); ecall_i = 1'b1; inst_pc_i = 32'h900;
      @(posedge clk);
      @(negedge clk); ecall_i = 1'b0;
      begin
         logic        w;
         logic [11:0] a;
         logic [31:0] d;
         w = csr_we; a = csr_addr; d = csr_wdata;
         @(posedge clk);
         #1 if (w) csr_write(a, d);
      end
      @(negedge clk);
      chk("rst_pre_addr", {20'b0, csr_addr}, 32'h342);
      rst_n = 1'b0;
      #1;
      chk("rst_ctl", {29'b0, csr_we, trap_busy_o, trap_jump_o}, 0);
      chk("rst_addr", {20'b0, csr_addr}, 0);
      chk("rst_wdata", csr_wdata, 0);
      chk("rst_jpc", trap_jump_pc_o, 0);
      chk("rst_mepc_kept", m_epc, 32'h900);
      chk("rst_mcause_untouched", m_cause, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model(4'b0010, 3'b000, 32'h904, 32'h908, 32'h73);
      run(4'b0010, 3'b000, 32'h904, 32'h908, 32'h73);
      cmp_list("post_rst");
      for (int n = 0; n < 200; n++) begin
         logic [3:0]  rq;
         logic [2:0]  iq;
         logic [31:0] pc, npc, inst;
         rq = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 2) == 0) rq = 0;
         iq = 3'($urandom_range(0, 7));
         m_status = $urandom; m_tvec = $urandom; m_epc = $urandom;
         m_cause = $urandom; m_tval = $urandom;
         pc = $urandom; npc = $urandom; inst = $urandom;
         model(rq, iq, pc, npc, inst);
         run(rq, iq, pc, npc, inst);
         cmp_list($sformatf("rnd%0d", n));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
